// File: rtl/hazard_stall_unit.sv
// ID-stage stall generator: load-use hazards and multi-cycle mult/div interlock.
// Latency: Stall/MD_Start combinational from ID/EX fields; HiLo_Write MD_LAT-1 cycles after MD_Start.
// Backpressure: Stall holds PC and IF_ID and injects an ID_EX bubble; Flush overrides any stall.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   ID_rs/ID_rt/ID_use_rs/_rt    source registers of the instruction in ID and their use flags
//   ID_MulDiv, ID_ReadHiLo       ID instruction starts mult/div, or reads HI/LO
//   EX_MemRead, EX_rt            load in EX and its destination register
//   Flush                        ID instruction squashed this cycle
//   Stall, PC_Write, IF_ID_Write, ID_EX_Bubble   pipeline hold controls
//   MD_Start, MD_Busy, HiLo_Write                mult/div sequencing strobes
//   Stall_Count                  saturating count of stall cycles since reset
module hazard_stall_unit #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 3,
    parameter int SC_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ID_rs,
    input  logic [4:0]      ID_rt,
    input  logic            ID_use_rs,
    input  logic            ID_use_rt,
    input  logic            ID_MulDiv,
    input  logic            ID_ReadHiLo,
    input  logic            EX_MemRead,
    input  logic [4:0]      EX_rt,
    input  logic            Flush,
    output logic            Stall,
    output logic            PC_Write,
    output logic            IF_ID_Write,
    output logic            ID_EX_Bubble,
    output logic            MD_Start,
    output logic            MD_Busy,
    output logic            HiLo_Write,
    output logic [SC_W-1:0] Stall_Count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // MD_Start cycle N, then BUSY for MD_LAT-2 cycles, then DONE in cycle
    // N+MD_LAT-1. The counter holds "remaining BUSY cycles minus one", so
    // BUSY exits when it reads zero. With MD_LAT==2 there is no BUSY cycle.
    localparam int              BUSY_CYC = MD_LAT - 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((BUSY_CYC > 0) ? (BUSY_CYC - 1) : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             md_hz;
    logic             idle;

    assign idle = (state == IDLE);

    // A load in EX can only be covered by MEM forwarding one cycle later,
    // so exactly one bubble is needed. $zero is never a real dependency.
    always_comb begin
        load_use = 1'b0;
        if (EX_MemRead && (EX_rt != 5'd0)) begin
            load_use = (ID_use_rs && (EX_rt == ID_rs)) ||
                       (ID_use_rt && (EX_rt == ID_rt));
        end
    end

    // Any HI/LO consumer or a second mult/div waits until the unit is IDLE,
    // including the DONE cycle in which HI/LO are still being written.
    assign md_hz = (ID_MulDiv || ID_ReadHiLo) && !idle;

    // A squashed instruction never stalls the front end.
    assign Stall        = !Flush && (load_use || md_hz);
    assign PC_Write     = !Stall;
    assign IF_ID_Write  = !Stall;
    assign ID_EX_Bubble = Stall;

    // A mult/div held back by a load-use stall simply retries next cycle.
    assign MD_Start   = ID_MulDiv && !Stall && !Flush && idle;
    assign MD_Busy    = !idle;
    assign HiLo_Write = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MD_Start) begin
                        state <= (BUSY_CYC > 0) ? BUSY : DONE;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    // Flush deliberately ignored: the operation is committed.
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Stall_Count <= '0;
        end else if (Stall && (Stall_Count != {SC_W{1'b1}})) begin
            Stall_Count <= Stall_Count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 3;
    localparam int SC_W   = 16;
    localparam int SC_MAX = (1 << SC_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4:0]      ID_rs, ID_rt, EX_rt;
    logic            ID_use_rs, ID_use_rt, ID_MulDiv, ID_ReadHiLo, EX_MemRead, Flush;
    logic            Stall, PC_Write, IF_ID_Write, ID_EX_Bubble;
    logic            MD_Start, MD_Busy, HiLo_Write;
    logic [SC_W-1:0] Stall_Count;

    int checks   = 0;
    int failures = 0;

    // Reference model: the mult/div unit is described only by the cycle its
    // operation was accepted; busy/commit windows follow from arithmetic.
    int cyc          = 0;
    int md_start_cyc = -1;
    int sc           = 0;

    // Last observed outputs, for directed spot checks.
    logic obs_stall, obs_start, obs_hilo, obs_busy;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MD_LAT(MD_LAT), .CNT_W(CNT_W), .SC_W(SC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_use_rs    (ID_use_rs),
        .ID_use_rt    (ID_use_rt),
        .ID_MulDiv    (ID_MulDiv),
        .ID_ReadHiLo  (ID_ReadHiLo),
        .EX_MemRead   (EX_MemRead),
        .EX_rt        (EX_rt),
        .Flush        (Flush),
        .Stall        (Stall),
        .PC_Write     (PC_Write),
        .IF_ID_Write  (IF_ID_Write),
        .ID_EX_Bubble (ID_EX_Bubble),
        .MD_Start     (MD_Start),
        .MD_Busy      (MD_Busy),
        .HiLo_Write   (HiLo_Write),
        .Stall_Count  (Stall_Count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, 32'(Stall), 32'd0);
        check({tag, "_pcw"},   32'(PC_Write), 32'd1);
        check({tag, "_ifidw"}, 32'(IF_ID_Write), 32'd1);
        check({tag, "_start"}, 32'(MD_Start), 32'd0);
        check({tag, "_busy"},  32'(MD_Busy), 32'd0);
        check({tag, "_hilo"},  32'(HiLo_Write), 32'd0);
        check({tag, "_cnt"},   32'(Stall_Count), 32'd0);
    endtask

    function automatic void model_reset();
        md_start_cyc = -1;
        sc           = 0;
    endfunction

    // One clock cycle: drive inputs just after a rising edge, compare at the
    // falling edge, then advance the model across the next rising edge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic md, input logic rh,
                        input logic mr, input logic [4:0] ert,
                        input logic fl, input bit chk_en);
        bit lu, busy, hilo, e_stall, e_start;
        ID_rs = rs; ID_rt = rt; ID_use_rs = urs; ID_use_rt = urt;
        ID_MulDiv = md; ID_ReadHiLo = rh; EX_MemRead = mr; EX_rt = ert; Flush = fl;
        @(negedge clk);
        lu      = mr && (ert != 0) && ((urs && ert == rs) || (urt && ert == rt));
        busy    = (md_start_cyc >= 0) && (cyc > md_start_cyc) && (cyc <= md_start_cyc + MD_LAT - 1);
        hilo    = (md_start_cyc >= 0) && (cyc == md_start_cyc + MD_LAT - 1);
        e_stall = !fl && (lu || ((md || rh) && busy));
        e_start = md && !e_stall && !fl && !busy;
        if (chk_en) begin
            check("stall",    32'(Stall), 32'(e_stall));
            check("pc_write", 32'(PC_Write), 32'(!e_stall));
            check("ifid_wr",  32'(IF_ID_Write), 32'(!e_stall));
            check("bubble",   32'(ID_EX_Bubble), 32'(e_stall));
            check("md_start", 32'(MD_Start), 32'(e_start));
            check("md_busy",  32'(MD_Busy), 32'(busy));
            check("hilo_wr",  32'(HiLo_Write), 32'(hilo));
            check("stall_cnt", 32'(Stall_Count), 32'(sc));
        end
        obs_stall = Stall; obs_start = MD_Start; obs_hilo = HiLo_Write; obs_busy = MD_Busy;
        @(posedge clk);
        if (e_start) md_start_cyc = cyc;
        if (e_stall && sc < SC_MAX) sc++;
        cyc++;
        #1;
    endtask

    task automatic idle_step();
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    initial begin
        // Power-on reset, no clock edge yet.
        rst_n = 1'b0;
        ID_rs = '0; ID_rt = '0; ID_use_rs = 0; ID_use_rt = 0;
        ID_MulDiv = 0; ID_ReadHiLo = 0; EX_MemRead = 0; EX_rt = '0; Flush = 0;
        #3;
        check_reset_outputs("por");
        #9 rst_n = 1'b1;           // t=12, between edges
        @(posedge clk); #1;
        model_reset();

        // Load-use: lw $5 in EX, add $3,$5,$2 in ID.
        step(5'd5, 5'd2, 1, 1, 0, 0, 1, 5'd5, 0, 1);
        check("lu_stall", 32'(obs_stall), 32'd1);
        check("lu_cnt_after", 32'(Stall_Count), 32'd1);
        step(5'd5, 5'd2, 1, 1, 0, 0, 0, 5'd0, 0, 1);   // load has moved on
        check("lu_released", 32'(obs_stall), 32'd0);
        step(5'd0, 5'd2, 1, 1, 0, 0, 1, 5'd0, 0, 1);   // $zero load dest
        check("lu_zero", 32'(obs_stall), 32'd0);
        step(5'd5, 5'd2, 0, 1, 0, 0, 1, 5'd5, 0, 1);   // rs unused
        check("lu_unused_rs", 32'(obs_stall), 32'd0);

        // mult then mfhi: start N, stall N+1..N+3, HiLo at N+3, go at N+4.
        step(5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, 1);
        check("mult_start", 32'(obs_start), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, 1);
            check($sformatf("mfhi_stall_%0d", i), 32'(obs_stall), 32'd1);
            check($sformatf("mfhi_hilo_%0d", i), 32'(obs_hilo), 32'(i == 3));
        end
        step(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, 1);
        check("mfhi_go", 32'(obs_stall), 32'd0);
        check("md_idle", 32'(obs_busy), 32'd0);

        // Flushed mult never starts.
        step(5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 1, 1);
        check("flush_start", 32'(obs_start), 32'd0);
        idle_step();
        check("flush_idle", 32'(obs_busy), 32'd0);

        // Load-use blocks a mult; it retries next cycle.
        step(5'd7, 5'd2, 1, 1, 1, 0, 1, 5'd7, 0, 1);
        check("lu_md_stall", 32'(obs_stall), 32'd1);
        check("lu_md_nostart", 32'(obs_start), 32'd0);
        step(5'd7, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, 1);
        check("lu_md_retry", 32'(obs_start), 32'd1);

        // Reset while BUSY: immediate IDLE, no HiLo pulse afterwards.
        idle_step();
        rst_n = 1'b0;
        #2;
        check_reset_outputs("mid_busy");
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            idle_step();
            check("no_hilo_after_rst", 32'(obs_hilo), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) < 1), 1);
        end

        // Saturation: pump load-use stalls up to 0xFFFE, then 3 more.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        while (sc != SC_MAX - 1)
            step(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0, 0);
        check("sat_fffe", 32'(Stall_Count), 32'hFFFE);
        for (int i = 0; i < 3; i++)
            step(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0, 1);
        check("sat_ffff", 32'(Stall_Count), 32'hFFFF);
        for (int i = 0; i < 3; i++)
            step(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0, 1);
        check("sat_hold", 32'(Stall_Count), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
